// File: rtl/sift_pkg.sv
// Shared types and constants for the SIFT keypoint front end.
package sift_pkg;
  localparam int DOG_WIDTH = 9;

  typedef enum logic [1:0] {
    INACTIVE = 2'd0,
    FETCH    = 2'd1,
    COMPARE  = 2'd2,
    EMIT     = 2'd3
  } module_state;

  function automatic logic [1:0] state_code(input module_state s);
    return 2'(s);
  endfunction
endpackage

// File: rtl/dog_extremum_check.sv
// Registered strict 3x3 extremum test on signed DoG values against a contrast threshold.
module dog_extremum_check
  import sift_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_in,
  input  logic [9*DOG_WIDTH-1:0]   win,
  input  logic [7:0]               threshold,
  output logic                     is_max,
  output logic                     is_min
);
  logic signed [DOG_WIDTH:0] center;
  logic signed [DOG_WIDTH:0] thr;
  logic signed [DOG_WIDTH:0] nb;
  logic is_max_d, is_min_d, is_max_q, is_min_q;

  // One extra bit so that -255 is representable for the minimum test.
  always_comb begin
    center   = {win[5*DOG_WIDTH-1], win[4*DOG_WIDTH +: DOG_WIDTH]};
    thr      = {2'b00, threshold};
    nb       = '0;
    is_max_d = (center > thr);
    is_min_d = (center < -thr);
    for (int i = 0; i < 9; i++) begin
      if (i != 4) begin
        nb = {win[i*DOG_WIDTH+DOG_WIDTH-1], win[i*DOG_WIDTH +: DOG_WIDTH]};
        if (nb >= center) is_max_d = 1'b0;
        if (nb <= center) is_min_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      is_max_q <= 1'b0;
      is_min_q <= 1'b0;
    end else begin
      is_max_q <= is_max_d;
      is_min_q <= is_min_d;
    end
  end

  assign is_max = is_max_q;
  assign is_min = is_min_q;
endmodule

// File: rtl/dog_extrema_reader.sv
// Scans interior pixels of one DoG BRAM, reads each 3x3 window and emits strict extrema.
module dog_extrema_reader
  import sift_pkg::*;
#(
  parameter int DIMENSION    = 64,
  parameter int BRAM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_in,
  input  logic        dog_ready,
  input  logic [7:0]  threshold,
  input  logic [8:0]  dog_pix,
  output logic [11:0] address,
  output logic        busy,
  output logic        kp_valid,
  input  logic        kp_ready,
  output logic [11:0] kp_x,
  output logic [11:0] kp_y,
  output logic        kp_is_max,
  output logic        done,
  output logic [1:0]  state_num
);
  localparam logic [11:0] DIM12 = 12'(DIMENSION);
  localparam logic [11:0] LAST  = 12'(DIMENSION - 2);
  localparam logic [3:0]  LAT   = 4'(BRAM_LATENCY);

  module_state state_q, state_d;
  logic [11:0] x_q, x_d, y_q, y_d, address_q, address_d;
  logic [11:0] kp_x_q, kp_x_d, kp_y_q, kp_y_d;
  logic [3:0]  k_q, k_d, wait_q, wait_d;
  logic [7:0]  thr_q, thr_d;
  logic        dog_ready_q, busy_q, busy_d, done_q, done_d;
  logic        kp_valid_q, kp_valid_d, kp_is_max_q, kp_is_max_d;
  logic [DOG_WIDTH-1:0] win_q [9];
  logic [DOG_WIDTH-1:0] win_d [9];
  logic [9*DOG_WIDTH-1:0] win_flat;
  logic [11:0] row_off, col_off, fetch_addr;
  logic        start, advance, is_max, is_min;

  // The checker registers the next window, so its verdict is ready during COMPARE.
  dog_extremum_check u_check (
    .clk       (clk),
    .rst_in    (rst_in),
    .win       (win_flat),
    .threshold (thr_q),
    .is_max    (is_max),
    .is_min    (is_min)
  );

  always_comb begin
    start = dog_ready & ~dog_ready_q;
    if (k_q >= 4'd6)      row_off = 12'd2;
    else if (k_q >= 4'd3) row_off = 12'd1;
    else                  row_off = 12'd0;
    col_off    = 12'(k_q) - 12'd3 * row_off;
    fetch_addr = (y_q + row_off - 12'd1) * DIM12 + (x_q + col_off - 12'd1);

    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    k_d         = k_q;
    wait_d      = wait_q;
    thr_d       = thr_q;
    address_d   = address_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    kp_valid_d  = kp_valid_q;
    kp_x_d      = kp_x_q;
    kp_y_d      = kp_y_q;
    kp_is_max_d = kp_is_max_q;
    win_d       = win_q;
    advance     = 1'b0;

    case (state_q)
      INACTIVE: if (start) begin
        busy_d  = 1'b1;
        thr_d   = threshold;
        x_d     = 12'd1;
        y_d     = 12'd1;
        k_d     = 4'd0;
        wait_d  = 4'd0;
        state_d = FETCH;
      end
      // address is issued on wait 0 and held; dog_pix is captured on wait LAT
      FETCH: begin
        if (wait_q == 4'd0) begin
          address_d = fetch_addr;
          wait_d    = wait_q + 4'd1;
        end else if (wait_q == LAT) begin
          win_d[k_q] = dog_pix;
          wait_d     = 4'd0;
          if (k_q == 4'd8) begin
            k_d     = 4'd0;
            state_d = COMPARE;
          end else begin
            k_d = k_q + 4'd1;
          end
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      COMPARE: begin
        if (is_max | is_min) begin
          kp_x_d      = x_q;
          kp_y_d      = y_q;
          kp_is_max_d = is_max;
          kp_valid_d  = 1'b1;
          state_d     = EMIT;
        end else begin
          advance = 1'b1;
        end
      end
      // Handshake: kp_* hold while kp_valid is high; transfer on kp_valid & kp_ready.
      EMIT: if (kp_valid_q & kp_ready) begin
        kp_valid_d = 1'b0;
        advance    = 1'b1;
      end
      default: state_d = INACTIVE;
    endcase

    if (advance) begin
      k_d    = 4'd0;
      wait_d = 4'd0;
      if (x_q == LAST && y_q == LAST) begin
        busy_d    = 1'b0;
        done_d    = 1'b1;
        address_d = 12'd0;
        x_d       = 12'd1;
        y_d       = 12'd1;
        state_d   = INACTIVE;
      end else begin
        if (x_q == LAST) begin
          x_d = 12'd1;
          y_d = y_q + 12'd1;
        end else begin
          x_d = x_q + 12'd1;
        end
        state_d = FETCH;
      end
    end

    for (int i = 0; i < 9; i++) win_flat[i*DOG_WIDTH +: DOG_WIDTH] = win_d[i];
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q     <= INACTIVE;
      x_q         <= 12'd1;
      y_q         <= 12'd1;
      k_q         <= 4'd0;
      wait_q      <= 4'd0;
      thr_q       <= 8'd0;
      address_q   <= 12'd0;
      dog_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      kp_valid_q  <= 1'b0;
      kp_x_q      <= 12'd0;
      kp_y_q      <= 12'd0;
      kp_is_max_q <= 1'b0;
      for (int i = 0; i < 9; i++) win_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      k_q         <= k_d;
      wait_q      <= wait_d;
      thr_q       <= thr_d;
      address_q   <= address_d;
      dog_ready_q <= dog_ready;
      busy_q      <= busy_d;
      done_q      <= done_d;
      kp_valid_q  <= kp_valid_d;
      kp_x_q      <= kp_x_d;
      kp_y_q      <= kp_y_d;
      kp_is_max_q <= kp_is_max_d;
      win_q       <= win_d;
    end
  end

  assign address   = address_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign kp_valid  = kp_valid_q;
  assign kp_x      = kp_x_q;
  assign kp_y      = kp_y_q;
  assign kp_is_max = kp_is_max_q;
  assign state_num = state_code(state_q);
endmodule

// File: tb/tb_dog_extrema_reader.sv
// Directed bench for dog_extrema_reader on an 8x8 image with a 2-cycle BRAM model.
module tb_dog_extrema_reader;
  localparam int DIM = 8;

  logic        clk = 1'b0;
  logic        rst_in = 1'b1;
  logic        dog_ready = 1'b0;
  logic [7:0]  threshold = 8'd0;
  logic [8:0]  dog_pix = 9'd0;
  logic [11:0] address;
  logic        busy, kp_valid, kp_is_max, done;
  logic        kp_ready = 1'b1;
  logic [11:0] kp_x, kp_y;
  logic [1:0]  state_num;

  logic [8:0]  mem [DIM*DIM];
  logic [24:0] exp_q[$];
  logic [24:0] kp_log[$];
  int tests_run = 0, tests_failed = 0;
  int busy_cnt = 0, done_cnt = 0, kp_cnt = 0;

  dog_extrema_reader #(.DIMENSION(DIM), .BRAM_LATENCY(2)) dut (
    .clk(clk), .rst_in(rst_in), .dog_ready(dog_ready), .threshold(threshold),
    .dog_pix(dog_pix), .address(address), .busy(busy), .kp_valid(kp_valid),
    .kp_ready(kp_ready), .kp_x(kp_x), .kp_y(kp_y), .kp_is_max(kp_is_max),
    .done(done), .state_num(state_num)
  );

  // clock / reset
  always #5 clk = ~clk;

  // BRAM: the registered address plus one output register make up the 2-cycle latency
  always @(posedge clk) dog_pix <= mem[address[5:0]];

  // monitor: cumulative counters and accepted keypoints
  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (kp_valid && kp_ready) begin
      kp_log.push_back({kp_x, kp_y, kp_is_max});
      kp_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_img();
    for (int i = 0; i < DIM*DIM; i++) mem[i] = 9'd0;
  endtask

  task automatic set_pix(input int x, input int y, input int v);
    mem[y*DIM + x] = 9'(v);
  endtask

  task automatic start_scan(input logic [7:0] thr);
    @(negedge clk);
    dog_ready = 1'b0;
    threshold = thr;
    @(negedge clk);
    dog_ready = 1'b1;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check({tag, "_timeout"}, 0, 1);
    @(negedge clk);
  endtask

  task automatic run_scan(input string tag, input logic [7:0] thr, input int exp_busy);
    int busy0, done0, kp0, n_exp;
    busy0 = busy_cnt;
    done0 = done_cnt;
    kp0   = kp_cnt;
    start_scan(thr);
    wait_done(tag);
    check({tag, "_busy"}, busy_cnt - busy0, exp_busy);
    check({tag, "_done"}, done_cnt - done0, 1);
    n_exp = exp_q.size();
    check({tag, "_kpcnt"}, kp_cnt - kp0, n_exp);
    for (int i = 0; i < n_exp && kp0 + i < kp_cnt; i++)
      check({tag, "_kp"}, 32'(kp_log[kp0 + i]), 32'(exp_q.pop_front()));
    exp_q.delete();
  endtask

  initial begin
    int hold, busy0, done0, kp0, n;
    clear_img();
    repeat (3) @(negedge clk);
    rst_in = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_kp_valid", kp_valid, 0);
    check("rst_address", address, 0);
    check("rst_done", done, 0);
    check("rst_state", state_num, 0);

    run_scan("zero", 8'd0, 1008);

    clear_img(); set_pix(3, 4, 50);
    exp_q.push_back({12'd3, 12'd4, 1'b1});
    run_scan("max", 8'd10, 1009);

    clear_img(); set_pix(5, 2, -50);
    exp_q.push_back({12'd5, 12'd2, 1'b0});
    run_scan("min", 8'd10, 1009);

    clear_img(); set_pix(0, 2, -50);
    run_scan("border", 8'd10, 1008);

    clear_img(); set_pix(3, 3, 50); set_pix(4, 3, 50);
    run_scan("plateau", 8'd10, 1008);

    clear_img(); set_pix(4, 4, 10);
    run_scan("thr_eq", 8'd10, 1008);

    clear_img(); set_pix(4, 4, 11);
    exp_q.push_back({12'd4, 12'd4, 1'b1});
    run_scan("thr_gt", 8'd10, 1009);

    // backpressure: ready low for 5 valid cycles, handshake on the 6th
    clear_img(); set_pix(2, 2, 50);
    busy0 = busy_cnt; kp0 = kp_cnt; hold = 0; n = 0;
    kp_ready = 1'b0;
    start_scan(8'd10);
    while (!kp_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid_seen", kp_valid, 1);
    for (int i = 0; i < 6; i++) begin
      if (kp_valid && kp_x == 12'd2 && kp_y == 12'd2 && kp_is_max) hold++;
      if (i == 5) kp_ready = 1'b1;
      else @(negedge clk);
    end
    @(negedge clk);
    check("bp_hold_cycles", hold, 6);
    check("bp_valid_drop", kp_valid, 0);
    check("bp_resume_state", state_num, 1);
    wait_done("bp");
    check("bp_busy", busy_cnt - busy0, 1014);
    check("bp_kpcnt", kp_cnt - kp0, 1);

    // second dog_ready edge while busy must not restart the scan
    clear_img();
    busy0 = busy_cnt; done0 = done_cnt;
    start_scan(8'd0);
    repeat (100) @(negedge clk);
    dog_ready = 1'b0;
    @(negedge clk);
    dog_ready = 1'b1;
    wait_done("restart");
    check("restart_busy", busy_cnt - busy0, 1008);
    check("restart_done", done_cnt - done0, 1);

    // reset in the middle of FETCH
    start_scan(8'd0);
    repeat (50) @(negedge clk);
    check("mid_state", state_num, 1);
    done0 = done_cnt;
    rst_in = 1'b1;
    dog_ready = 1'b0;
    @(negedge clk);
    rst_in = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_kp_valid", kp_valid, 0);
    check("mid_rst_address", address, 0);
    check("mid_rst_state", state_num, 0);
    repeat (1200) @(negedge clk);
    check("mid_rst_no_done", done_cnt - done0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
